// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Latency: req_ready is combinational in IDLE; te_out/data_out register on the transfer edge.
// Backpressure: one byte per frame; req_ready stays low while a frame, its gap or en=0 blocks grants.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ARM_TIMEOUT = 1024,
  parameter int GAP_CYCLES  = 2,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [3:0]           cfg_char_size,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 tx_busy_in,
  output logic                 te_out,
  output logic [7:0]           data_out,
  output logic [3:0]           char_size_out,
  output logic [IW-1:0]        grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int AW = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, ARM, WAIT_DONE, GAP} state_t;

  state_t          state, state_nxt;
  logic            busy_meta, busy_s;
  logic [IW-1:0]   ptr, winner, hi_idx, lo_idx;
  logic            hi_found, lo_found, any_vld;
  logic            grant, arm_expire, gap_done;
  logic [AW-1:0]   arm_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [3:0]      char_size_clamped;

  // Two-flop synchroniser for the baud-domain busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_meta <= 1'b0;
      busy_s    <= 1'b0;
    end else begin
      busy_meta <= tx_busy_in;
      busy_s    <= busy_meta;
    end
  end

  // Round-robin search: first valid above the pointer, else first valid at or below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        if (i > int'(ptr)) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_idx   = IW'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = IW'(i);
        end
      end
    end
    winner  = hi_found ? hi_idx : lo_idx;
    any_vld = hi_found | lo_found;
  end

  // A grant also waits for busy_s to clear, so a frame still running after reset is never overlapped.
  assign grant      = !rst && (state == IDLE) && en && any_vld && !busy_s;
  assign arm_expire = (arm_cnt == ARM_LAST);
  assign gap_done   = (gap_cnt == GAP_LAST);
  assign busy       = (state != IDLE);
  assign char_size_clamped = (cfg_char_size >= 4'd5 && cfg_char_size <= 4'd8) ? cfg_char_size : 4'd8;

  // One-hot accept strobe for the winning requester in the transfer cycle.
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; busy_s takes priority over the arm timeout on the same edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (grant) state_nxt = ARM;
      ARM: begin
        if (busy_s)          state_nxt = WAIT_DONE;
        else if (arm_expire) state_nxt = IDLE;
      end
      WAIT_DONE: if (!busy_s) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:       if (gap_done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Per-state counters; each clears whenever its state is (re)entered or left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      arm_cnt <= (state == ARM && state_nxt == ARM) ? arm_cnt + 1'b1 : '0;
      gap_cnt <= (state == GAP && state_nxt == GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

  // Transmitter-facing outputs; data and size only move on a transfer so they stay stable mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      te_out        <= 1'b0;
      timeout_err   <= 1'b0;
      data_out      <= 8'h00;
      char_size_out <= 4'd8;
      grant_id      <= '0;
      ptr           <= IW'(NUM_REQ - 1);
    end else begin
      te_out      <= (state_nxt == ARM);
      timeout_err <= (state == ARM) && !busy_s && arm_expire;
      if (grant) begin
        data_out      <= req_data[{winner, 3'b000} +: 8];
        char_size_out <= char_size_clamped;
        grant_id      <= winner;
        ptr           <= winner;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed frames, char-size table, reset/enable corners, random traffic.
// The transmitter is a behavioural model: after seeing te it raises busy after a delay for a length.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_uart_tx_arbiter;
  localparam int NR  = 2;
  localparam int ATO = 16;
  localparam int GAP = 2;
  localparam int IW  = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [3:0]      cfg_char_size;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            tx_busy_in;
  logic            te_out;
  logic [7:0]      data_out;
  logic [3:0]      char_size_out;
  logic [IW-1:0]   grant_id;
  logic            busy;
  logic            timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .ARM_TIMEOUT(ATO), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_char_size(cfg_char_size),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_busy_in(tx_busy_in), .te_out(te_out), .data_out(data_out),
    .char_size_out(char_size_out), .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err)
  );

  int total = 0;
  int bad   = 0;

  // transmitter model state
  int tx_phase = 0;
  int tx_cnt   = 0;
  int tx_delay = 5;
  int tx_len   = 40;
  bit tx_dead  = 0;
  bit tx_rand  = 0;
  int low_edges = 0;  // consecutive rising edges at which tx_busy_in was low

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] clamp_cs(input logic [3:0] c);
    return (c >= 4'd5 && c <= 4'd8) ? c : 4'd8;
  endfunction

  // One clock: record what the synchroniser sees, then advance the transmitter model.
  task automatic tick();
    @(posedge clk);
    if (tx_busy_in) low_edges = 0; else low_edges++;
    #1;
    if (tx_phase == 0) begin
      if (te_out && !tx_dead) begin
        if (tx_rand) begin
          tx_delay = $urandom_range(4, 1);
          tx_len   = $urandom_range(12, 3);
        end
        tx_phase = 1;
        tx_cnt   = tx_delay;
      end
    end else if (tx_phase == 1) begin
      if (tx_cnt <= 1) begin
        tx_busy_in = 1'b1;
        tx_phase   = 2;
        tx_cnt     = tx_len;
      end else tx_cnt--;
    end else begin
      if (tx_cnt <= 1) begin
        tx_busy_in = 1'b0;
        tx_phase   = 0;
      end else tx_cnt--;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; req_valid = '0; req_data = '0; cfg_char_size = 4'd8;
    tx_busy_in = 1'b0; tx_phase = 0; tx_dead = 0; tx_rand = 0;
    tick(); tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  // Offer one byte from requester idx and follow the frame until busy falls again.
  task automatic do_frame(input int idx, input logic [7:0] d, input logic [3:0] cfg,
                          output int n_rdy, output int n_te, output int n_busy, output int n_to,
                          output int n_hold_bad, output logic [7:0] d_seen,
                          output logic [3:0] cs_seen, output logic [IW-1:0] gid_seen,
                          output logic [7:0] d_after);
    bit acc, started, done;
    n_rdy = 0; n_te = 0; n_busy = 0; n_to = 0; n_hold_bad = 0;
    d_seen = '0; cs_seen = '0; gid_seen = '0; d_after = '0;
    acc = 0; started = 0; done = 0;
    req_valid[idx] = 1'b1;
    req_data[idx*8 +: 8] = d;
    cfg_char_size = cfg;
    for (int g = 0; g < 400 && !done; g++) begin
      @(negedge clk);
      if (req_ready[idx]) begin n_rdy++; acc = 1; end
      if (te_out) n_te++;
      if (timeout_err) n_to++;
      if (busy) begin
        if (!started) begin
          started = 1; d_seen = data_out; cs_seen = char_size_out; gid_seen = grant_id;
        end else if (data_out != d_seen || char_size_out != cs_seen || grant_id != gid_seen) begin
          n_hold_bad++;
        end
        n_busy++;
      end else if (started) begin
        done = 1; d_after = data_out;
      end
      tick();
      if (acc) req_valid[idx] = 1'b0;
    end
    chk("frame_completed", done, 1'b1);
  endtask

  typedef struct {
    logic [3:0] cfg;
    logic [7:0] d;
    logic [3:0] exp_cs;
  } cs_vec_t;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n_rdy, n_te, n_busy, n_to, n_hold;
    logic [7:0] d_seen, d_after;
    logic [3:0] cs_seen;
    logic [IW-1:0] gid_seen;
    cs_vec_t tbl[9];
    int seen[4];
    int n, early, waited;
    bit chk_next, acc, saw_te, reached, granted, done;
    int rdy_bad;

    // ---------------- reset state (requests pending while rst is held) ----------------
    rst = 1'b1; en = 1'b1; cfg_char_size = 4'd6; req_valid = 2'b11; req_data = 16'hB1A0;
    tx_busy_in = 1'b0;
    #2;
    chk("rst_te", te_out, 0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_cs", char_size_out, 4'd8);
    chk("rst_gid", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_ready", req_ready, 2'b00);

    // ---------------- single frame: delay 5, length 40 ----------------
    do_reset();
    tx_delay = 5; tx_len = 40;
    do_frame(0, 8'h41, 4'd8, n_rdy, n_te, n_busy, n_to, n_hold, d_seen, cs_seen, gid_seen, d_after);
    chk("f1_ready_cycles", n_rdy, 1);
    // te falls on the third edge after busy_in rises: two synchroniser stages plus the state register
    chk("f1_te_cycles", n_te, 5 + 3);
    // busy: delay + length + 3 edges to see busy_in fall + GAP cycles
    chk("f1_busy_cycles", n_busy, 5 + 40 + 3 + GAP);
    chk("f1_data", d_seen, 8'h41);
    chk("f1_cs", cs_seen, 4'd8);
    chk("f1_gid", gid_seen, 0);
    chk("f1_hold", n_hold, 0);
    chk("f1_no_timeout", n_to, 0);
    chk("f1_data_after", d_after, 8'h41);

    // ---------------- round robin with both requesters always valid ----------------
    do_reset();
    tx_delay = 2; tx_len = 6;
    req_valid = 2'b11; req_data = 16'hB1A0; cfg_char_size = 4'd8;
    n = 0; chk_next = 0;
    for (int g = 0; g < 400 && n < 4; g++) begin
      @(negedge clk);
      if (chk_next) begin
        chk("rr_gid", grant_id, seen[n-1]);
        chk("rr_data", data_out, (seen[n-1] == 1) ? 8'hB1 : 8'hA0);
        chk_next = 0;
      end
      if (req_ready != 0) begin
        chk("rr_onehot", $countones(req_ready), 1);
        seen[n] = req_ready[1] ? 1 : 0;
        n++;
        chk_next = 1;
      end
      tick();
    end
    @(negedge clk);
    if (chk_next) begin
      chk("rr_gid", grant_id, seen[n-1]);
      chk("rr_data", data_out, (seen[n-1] == 1) ? 8'hB1 : 8'hA0);
    end
    chk("rr_grant_count", n, 4);
    for (int i = 0; i < 4 && i < n; i++) chk("rr_order", seen[i], i % 2);
    req_valid = '0;

    // ---------------- arm timeout: transmitter never answers ----------------
    do_reset();
    tx_dead = 1;
    do_frame(0, 8'h5A, 4'd8, n_rdy, n_te, n_busy, n_to, n_hold, d_seen, cs_seen, gid_seen, d_after);
    chk("to_te_cycles", n_te, ATO);
    chk("to_busy_cycles", n_busy, ATO);
    chk("to_pulses", n_to, 1);
    tx_dead = 0; tx_delay = 1; tx_len = 3;
    do_frame(1, 8'h3C, 4'd7, n_rdy, n_te, n_busy, n_to, n_hold, d_seen, cs_seen, gid_seen, d_after);
    chk("to_next_ready", n_rdy, 1);
    chk("to_next_gid", gid_seen, 1);
    chk("to_next_data", d_seen, 8'h3C);
    chk("to_next_cs", cs_seen, 4'd7);
    chk("to_next_no_timeout", n_to, 0);

    // ---------------- char size clamp table ----------------
    tbl[0] = '{cfg: 4'd3,  d: 8'h10, exp_cs: 4'd8};
    tbl[1] = '{cfg: 4'd12, d: 8'h21, exp_cs: 4'd8};
    tbl[2] = '{cfg: 4'd6,  d: 8'h32, exp_cs: 4'd6};
    tbl[3] = '{cfg: 4'd5,  d: 8'h43, exp_cs: 4'd5};
    tbl[4] = '{cfg: 4'd8,  d: 8'h54, exp_cs: 4'd8};
    tbl[5] = '{cfg: 4'd0,  d: 8'h65, exp_cs: 4'd8};
    tbl[6] = '{cfg: 4'd4,  d: 8'h76, exp_cs: 4'd8};
    tbl[7] = '{cfg: 4'd9,  d: 8'h87, exp_cs: 4'd8};
    tbl[8] = '{cfg: 4'd7,  d: 8'h98, exp_cs: 4'd7};
    do_reset();
    tx_delay = 1; tx_len = 3;
    for (int v = 0; v < 9; v++) begin
      do_frame(0, tbl[v].d, tbl[v].cfg, n_rdy, n_te, n_busy, n_to, n_hold, d_seen, cs_seen, gid_seen, d_after);
      chk("tbl_cs", cs_seen, tbl[v].exp_cs);
      chk("tbl_data", d_seen, tbl[v].d);
    end

    // ---------------- reset during WAIT_DONE ----------------
    do_reset();
    tx_delay = 2; tx_len = 30;
    req_valid[0] = 1'b1; req_data[7:0] = 8'h99; cfg_char_size = 4'd8;
    acc = 0; saw_te = 0; reached = 0;
    for (int g = 0; g < 100 && !reached; g++) begin
      @(negedge clk);
      if (req_ready[0]) acc = 1;
      if (te_out) saw_te = 1;
      else if (saw_te && busy) reached = 1;
      if (!reached) begin
        tick();
        if (acc) req_valid[0] = 1'b0;
      end
    end
    chk("rw_wait_done_reached", reached, 1);
    chk("rw_data_before", data_out, 8'h99);
    rst = 1'b1; req_valid = '0;
    #1;
    chk("rw_te_async", te_out, 0);
    chk("rw_data_async", data_out, 8'h00);
    chk("rw_busy_async", busy, 0);
    chk("rw_cs_async", char_size_out, 4'd8);
    tick(); tick();
    @(negedge clk);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("rw_tx_still_busy", tx_busy_in, 1);
    req_valid[0] = 1'b1; req_data[7:0] = 8'h11;
    early = 0; waited = 0; granted = 0;
    for (int g = 0; g < 100 && !granted; g++) begin
      @(negedge clk);
      if (low_edges < 2) begin
        if (req_ready != 0) early++;
        waited++;
        tick();
      end else begin
        chk("rw_grant_after_clear", req_ready, 2'b01);
        granted = 1;
      end
    end
    chk("rw_granted", granted, 1);
    chk("rw_no_early_grant", early, 0);
    chk("rw_waited", waited >= 15, 1);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("rw_post_data", data_out, 8'h11);
    chk("rw_post_te", te_out, 1);

    // ---------------- en dropped during WAIT_DONE with req1 pending ----------------
    do_reset();
    tx_delay = 2; tx_len = 20;
    req_valid[0] = 1'b1; req_data[7:0] = 8'h99; cfg_char_size = 4'd8;
    acc = 0; saw_te = 0; reached = 0;
    for (int g = 0; g < 100 && !reached; g++) begin
      @(negedge clk);
      if (req_ready[0]) acc = 1;
      if (te_out) saw_te = 1;
      else if (saw_te && busy) reached = 1;
      if (!reached) begin
        tick();
        if (acc) req_valid[0] = 1'b0;
      end
    end
    chk("en_wait_done_reached", reached, 1);
    en = 1'b0; req_valid[1] = 1'b1; req_data[15:8] = 8'h77;
    rdy_bad = 0; done = 0;
    for (int g = 0; g < 100 && !done; g++) begin
      @(negedge clk);
      if (req_ready != 0) rdy_bad++;
      if (!busy) done = 1;
      else tick();
    end
    chk("en_frame_completed", done, 1);
    chk("en_data_held", data_out, 8'h99);
    for (int g = 0; g < 10; g++) begin
      tick();
      @(negedge clk);
      if (req_ready != 0 || busy) rdy_bad++;
    end
    chk("en_no_grant_while_low", rdy_bad, 0);
    en = 1'b1;
    #1;
    chk("en_grant_on_return", req_ready, 2'b10);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("en_gid", grant_id, 1);
    chk("en_data", data_out, 8'h77);

    // ---------------- randomized traffic against a transaction-level model ----------------
    begin : rnd
      int mdl_ptr, exp_w, w, grants, exp_to, obs_to;
      logic [7:0] mdl_data, new_data;
      logic [3:0] mdl_cs, new_cs;
      int mdl_gid, new_gid;
      bit pend, expect_te;
      logic [NR-1:0] acc_v;
      do_reset();
      tx_rand = 1;
      mdl_ptr = NR - 1; mdl_data = 8'h00; mdl_cs = 4'd8; mdl_gid = 0;
      grants = 0; exp_to = 0; obs_to = 0; pend = 0; expect_te = 0;
      new_data = '0; new_cs = '0; new_gid = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
        @(negedge clk);
        chk("rnd_data_hold", data_out, mdl_data);
        chk("rnd_cs_hold", char_size_out, mdl_cs);
        chk("rnd_gid_hold", grant_id, mdl_gid);
        if (expect_te) chk("rnd_te_after_grant", te_out, 1);
        expect_te = 0;
        if (timeout_err) obs_to++;
        acc_v = '0;
        if (req_ready != 0) begin
          exp_w = -1;
          for (int k = 1; k <= NR; k++) begin
            int j;
            j = (mdl_ptr + k) % NR;
            if (exp_w < 0 && req_valid[j]) exp_w = j;
          end
          chk("rnd_onehot", $countones(req_ready), 1);
          chk("rnd_grant_en", en, 1);
          chk("rnd_grant_idle", busy, 0);
          chk("rnd_grant_tx_clear", low_edges >= 2, 1);
          chk("rnd_winner", req_ready, (exp_w >= 0) ? (32'd1 << exp_w) : 32'd0);
          w = 0;
          for (int i = 0; i < NR; i++) if (req_ready[i]) w = i;
          mdl_ptr = w;
          new_data = req_data[w*8 +: 8];
          new_cs = clamp_cs(cfg_char_size);
          new_gid = w;
          pend = 1;
          acc_v[w] = 1'b1;
          grants++;
          tx_dead = ($urandom_range(7) == 0);
          if (tx_dead) exp_to++;
        end
        tick();
        if (pend) begin
          mdl_data = new_data; mdl_cs = new_cs; mdl_gid = new_gid;
          pend = 0; expect_te = 1;
        end
        for (int i = 0; i < NR; i++) begin
          if (acc_v[i]) req_valid[i] = 1'b0;
          if (!req_valid[i] && $urandom_range(2) == 0) begin
            req_valid[i] = 1'b1;
            req_data[i*8 +: 8] = 8'($urandom);
          end else if (req_valid[i] && $urandom_range(19) == 0) begin
            req_valid[i] = 1'b0;
          end
        end
        if ($urandom_range(29) == 0) en = ~en;
        cfg_char_size = 4'($urandom_range(15));
      end
      req_valid = '0; en = 1'b1;
      done = 0;
      for (int g = 0; g < 200 && !done; g++) begin
        @(negedge clk);
        if (expect_te) chk("rnd_te_after_grant", te_out, 1);
        expect_te = 0;
        if (timeout_err) obs_to++;
        if (!busy && !timeout_err && tx_phase == 0 && g > 2) done = 1;
        else tick();
      end
      chk("rnd_drained", done, 1);
      chk("rnd_timeouts", obs_to, exp_to);
      chk("rnd_enough_grants", grants >= 10, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
